// File: rtl/mux_dff_chain.sv
// DEPTH-stage WIDTH-bit shift/load chain: every stage is a mux in front of a DFF.
// Supports parallel load, bidirectional shift/rotate, and a saturating fill counter.
module mux_dff_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             L,
    input  logic             E,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] shift_in,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (L)   q <= r;
        else if (E)   q <= shift_in;
    end
endmodule

module mux_dff_chain #(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   L,
    input  logic                   E,
    input  logic                   dir,
    input  logic                   rot,
    input  logic [WIDTH-1:0]       w,
    input  logic [DEPTH*WIDTH-1:0] R,
    output logic [DEPTH*WIDTH-1:0] Q,
    output logic [WIDTH-1:0]       so_q,
    output logic [FW-1:0]          fill,
    output logic                   full
);
    localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] st, r_st, from_lo, from_hi, shift_in;
    logic [WIDTH-1:0]            ins;
    logic [FW-1:0]               fill_inc;

    assign r_st = R;
    assign Q    = st;
    assign so_q = dir ? st[0] : st[DEPTH-1];
    // The stage ejected by this shift is exactly so_q, so rotate recycles it.
    assign ins  = rot ? so_q : w;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_lo_end
                assign from_lo[i] = ins;
            end else begin : g_lo_mid
                assign from_lo[i] = st[i-1];
            end
            if (i == DEPTH - 1) begin : g_hi_end
                assign from_hi[i] = ins;
            end else begin : g_hi_mid
                assign from_hi[i] = st[i+1];
            end
            assign shift_in[i] = dir ? from_hi[i] : from_lo[i];

            mux_dff_stage #(.WIDTH(WIDTH)) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr      (clr),
                .L        (L),
                .E        (E),
                .r        (r_st[i]),
                .shift_in (shift_in[i]),
                .q        (st[i])
            );
        end
    endgenerate

    assign fill_inc = (fill == FULL_CNT) ? FULL_CNT : fill + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
            full <= 1'b0;
        end else if (clr) begin
            fill <= '0;
            full <= 1'b0;
        end else if (L) begin
            fill <= FULL_CNT;
            full <= 1'b1;
        end else if (E && !rot) begin
            fill <= fill_inc;
            full <= (fill_inc == FULL_CNT);
        end
    end
endmodule
